// File: rtl/store_buffer.sv
// store_buffer: decoupling store queue between the EX/MEM register and DataMemory.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   i_req_valid/addr/data/write/read/size/sign
//                                    pipeline memory request
//   i_fence                          hold every request until the queue is empty
//   o_stall, o_rdata, o_exception    pipeline response (load data has zero latency)
//   o_buf_empty                      queue holds no stores
//   i_mem_grant                      memory port available this cycle
//   o_mem_addr/din/write/read/size/sign, i_mem_dout
//                                    DataMemory port (combinational read)
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_data,
    input  logic        i_req_write,
    input  logic        i_req_read,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_sign,
    input  logic        i_fence,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_exception,
    output logic        o_buf_empty,
    input  logic        i_mem_grant,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_din,
    output logic        o_mem_write,
    output logic        o_mem_read,
    output logic [1:0]  o_mem_size,
    output logic        o_mem_sign,
    input  logic [31:0] i_mem_dout
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [1:0]    r_size [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;

    logic w_aligned, w_bad, w_is_load, w_is_store, w_hazard, w_fstall;
    logic w_load_go, w_enq, w_drain;

    assign w_aligned  = (i_req_size == 2'b00) ||
                        (i_req_size == 2'b01 && !i_req_addr[0]) ||
                        (i_req_size == 2'b10 && i_req_addr[1:0] == 2'b00);
    assign w_bad      = !rst && i_req_valid && (i_req_write || i_req_read) && !w_aligned;
    assign w_is_load  = i_req_valid && i_req_read && !i_req_write && w_aligned;
    assign w_is_store = i_req_valid && i_req_write && w_aligned;
    assign w_fstall   = i_fence && (r_count != '0);

    // An entry is live when its distance from head is below count.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if ({1'b0, PW'(i) - r_head} < r_count && r_addr[i][31:2] == i_req_addr[31:2])
                w_hazard = 1'b1;
    end

    assign w_load_go = !rst && w_is_load && !w_hazard && i_mem_grant && !w_fstall;
    assign w_enq     = !rst && w_is_store && (r_count != (PW+1)'(DEPTH)) && !w_fstall;
    // Accepted loads own the port; otherwise the head store retires.
    assign w_drain   = !rst && (r_count != '0) && i_mem_grant && !w_load_go;

    assign o_stall     = !rst && ((w_is_load && !w_load_go) || (w_is_store && !w_enq));
    assign o_exception = w_bad;
    assign o_buf_empty = r_count == '0;
    assign o_rdata     = w_load_go ? i_mem_dout : 32'd0;
    assign o_mem_read  = w_load_go;
    assign o_mem_write = w_drain;
    assign o_mem_addr  = w_load_go ? i_req_addr : r_addr[r_head];
    assign o_mem_din   = w_load_go ? i_req_data : r_data[r_head];
    assign o_mem_size  = w_load_go ? i_req_size : r_size[r_head];
    assign o_mem_sign  = w_load_go && i_req_sign;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_addr[r_tail] <= i_req_addr;
                r_data[r_tail] <= i_req_data;
                r_size[r_tail] <= i_req_size;
                r_tail         <= r_tail + 1'b1;
            end
            if (w_drain)
                r_head <= r_head + 1'b1;
            r_count <= r_count + (PW+1)'(w_enq) - (PW+1)'(w_drain);
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: randomized scoreboard bench for store_buffer with a behavioural DataMemory.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req_valid = 1'b0, i_req_write = 1'b0, i_req_read = 1'b0, i_req_sign = 1'b0;
    logic        i_fence = 1'b0, i_mem_grant = 1'b1;
    logic [31:0] i_req_addr = '0, i_req_data = '0;
    logic [1:0]  i_req_size = '0;
    logic        o_stall, o_exception, o_buf_empty, o_mem_write, o_mem_read, o_mem_sign;
    logic [31:0] o_rdata, o_mem_addr, o_mem_din, i_mem_dout;
    logic [1:0]  o_mem_size;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
        .i_req_write(i_req_write), .i_req_read(i_req_read), .i_req_size(i_req_size),
        .i_req_sign(i_req_sign), .i_fence(i_fence),
        .o_stall(o_stall), .o_rdata(o_rdata), .o_exception(o_exception), .o_buf_empty(o_buf_empty),
        .i_mem_grant(i_mem_grant), .o_mem_addr(o_mem_addr), .o_mem_din(o_mem_din),
        .o_mem_write(o_mem_write), .o_mem_read(o_mem_read), .o_mem_size(o_mem_size),
        .o_mem_sign(o_mem_sign), .i_mem_dout(i_mem_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          stall, exc, mrd, mwr, emp;
        logic [31:0] rdata;
    } ctl_t;
    typedef struct {
        logic [31:0] addr, data;
        logic [1:0]  size;
    } st_t;

    ctl_t        ctl_q[$];
    st_t         wr_q[$];
    logic [31:0] rd_q[$];
    st_t         pend[$];
    logic [31:0] cmem [16];
    logic [31:0] phys [16];
    int          checks = 0, errors = 0;

    function automatic logic [31:0] rd_fn(logic [31:0] w, logic [31:0] a, logic [1:0] sz, bit sg);
        logic [31:0] v;
        v = w >> (8 * a[1:0]);
        if (sz == 2'b00) return sg ? {{24{v[7]}}, v[7:0]} : {24'd0, v[7:0]};
        if (sz == 2'b01) return sg ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
        return v;
    endfunction

    function automatic logic [31:0] mg(logic [31:0] w, logic [31:0] a, logic [31:0] d, logic [1:0] sz);
        for (int b = 0; b < (1 << sz); b++)
            w[8 * (a[1:0] + b) +: 8] = d[8 * b +: 8];
        return w;
    endfunction

    initial for (int k = 0; k < 16; k++) begin
        phys[k] = '0;
        cmem[k] = '0;
    end

    always_comb i_mem_dout = rd_fn(phys[o_mem_addr[5:2]], o_mem_addr, o_mem_size, o_mem_sign);
    always @(posedge clk) if (o_mem_write === 1'b1)
        phys[o_mem_addr[5:2]] <= mg(phys[o_mem_addr[5:2]], o_mem_addr, o_mem_din, o_mem_size);

    task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", n, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        ctl_t c;
        st_t  s;
        if (ctl_q.size() != 0) begin
            c = ctl_q.pop_front();
            chk("stall", 32'(o_stall), 32'(c.stall));
            chk("exception", 32'(o_exception), 32'(c.exc));
            chk("mem_read", 32'(o_mem_read), 32'(c.mrd));
            chk("mem_write", 32'(o_mem_write), 32'(c.mwr));
            chk("buf_empty", 32'(o_buf_empty), 32'(c.emp));
            chk("rdata", o_rdata, c.rdata);
        end
        if (o_mem_write === 1'b1) begin
            if (wr_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
            else begin
                s = wr_q.pop_front();
                chk("drain_addr", o_mem_addr, s.addr);
                chk("drain_data", o_mem_din, s.data);
                chk("drain_size", 32'(o_mem_size), 32'(s.size));
            end
        end
        if (o_mem_read === 1'b1) begin
            if (rd_q.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
            else chk("load_addr", o_mem_addr, rd_q.pop_front());
        end
    end

    task automatic cyc(bit r, bit v, bit w, bit rd, logic [31:0] a, logic [31:0] d,
                       logic [1:0] sz, bit sg, bit f, bit g, bit chk_en = 1'b1);
        ctl_t c;
        int   n;
        bit   al, isl, iss, haz, lok, sok, dr;
        rst = r; i_req_valid = v; i_req_write = w; i_req_read = rd; i_req_addr = a;
        i_req_data = d; i_req_size = sz; i_req_sign = sg; i_fence = f; i_mem_grant = g;
        n   = pend.size();
        al  = sz != 2'd3 && (a % (32'd1 << sz)) == 0;
        isl = v && rd && !w && al;
        iss = v && w && al;
        haz = 1'b0;
        foreach (pend[k]) if (pend[k].addr[31:2] == a[31:2]) haz = 1'b1;
        lok = !r && isl && !haz && g && !(f && n > 0);
        sok = !r && iss && n < DEPTH && !(f && n > 0);
        dr  = !r && n > 0 && g && !lok;
        c.emp   = n == 0;
        c.stall = !r && ((isl && !lok) || (iss && !sok));
        c.exc   = !r && v && (w || rd) && !al;
        c.mrd   = lok;
        c.mwr   = dr;
        c.rdata = lok ? rd_fn(cmem[a[5:2]], a, sz, sg) : 32'd0;
        if (chk_en) ctl_q.push_back(c);
        if (dr) wr_q.push_back(pend[0]);
        if (lok) rd_q.push_back(a);
        @(posedge clk);
        #1;
        if (r) pend.delete();
        else begin
            if (dr) begin
                cmem[pend[0].addr[5:2]] = mg(cmem[pend[0].addr[5:2]], pend[0].addr, pend[0].data, pend[0].size);
                void'(pend.pop_front());
            end
            if (sok) pend.push_back('{a, d, sz});
        end
    endtask

    task automatic st(logic [31:0] a, logic [31:0] d, logic [1:0] sz, bit g, bit f = 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, a, d, sz, 1'b0, f, g);
    endtask
    task automatic ld(logic [31:0] a, logic [1:0] sz, bit sg, bit g, bit f = 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, a, 32'd0, sz, sg, f, g);
    endtask
    task automatic idle(bit g);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0, g);
    endtask
    task automatic rstc();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        rstc();
        st(32'h0, 32'h12345678, 2'd2, 1'b1);
        idle(1'b1); idle(1'b1);
        ld(32'h0, 2'd2, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) st(32'(4 * k), 32'hA0 + 32'(k), 2'd2, 1'b0);
        st(32'h10, 32'hA4, 2'd2, 1'b1);
        st(32'h10, 32'hA4, 2'd2, 1'b1);
        repeat (5) idle(1'b1);
        st(32'h4, 32'h5678, 2'd1, 1'b0);
        ld(32'h6, 2'd1, 1'b0, 1'b0);
        ld(32'h6, 2'd1, 1'b0, 1'b1);
        ld(32'h6, 2'd1, 1'b0, 1'b1);
        st(32'h8, 32'hCAFE, 2'd2, 1'b0);
        ld(32'h0, 2'd2, 1'b0, 1'b1);
        idle(1'b1);
        ld(32'h3, 2'd2, 1'b0, 1'b1);
        ld(32'h5, 2'd1, 1'b1, 1'b1);
        st(32'h2, 32'h1, 2'd2, 1'b1);
        ld(32'h0, 2'd3, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) st(32'h20 + 32'(4 * k), 32'hBEEF, 2'd2, 1'b0);
        rstc();
        idle(1'b1); idle(1'b1);
        st(32'h30, 32'h11, 2'd2, 1'b0);
        st(32'h34, 32'h22, 2'd2, 1'b0);
        st(32'h38, 32'h33, 2'd2, 1'b0, 1'b1);
        repeat (3) st(32'h38, 32'h33, 2'd2, 1'b1, 1'b1);
        for (int k = 0; k < 3000; k++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 63));
            if (sz != 2'd3 && $urandom_range(0, 9) != 0) a = a & ~((32'd1 << sz) - 1);
            if ($urandom_range(0, 199) == 0) rstc();
            else cyc(1'b0, $urandom_range(0, 4) != 0, 1'($urandom), 1'($urandom), a, $urandom, sz,
                     1'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
        end
        repeat (8) idle(1'b1);
        @(negedge clk);
        chk("wr_q_left", 32'(wr_q.size()), 32'd0);
        chk("rd_q_left", 32'(rd_q.size()), 32'd0);
        chk("pend_left", 32'(pend.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
